// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads 16 words into a circular buffer, then emits W0..W63 in place.
// Latency: W0 appears one cycle after the 16th accepted word; one word per cycle thereafter.
// Backpressure: out_ready low holds t and out_data; in_valid gaps stall the load without loss.
module sha256_msg_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [5:0]  out_index,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic {LOAD, EMIT} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic [31:0] msg_buf [16];
    logic [31:0] sched_dat;
    logic        in_acc, out_acc;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // 4-bit index arithmetic wraps the circular buffer for free.
    always_comb begin
        sched_dat = sig1(msg_buf[cnt[3:0] - 4'd2]) + msg_buf[cnt[3:0] - 4'd7]
                  + sig0(msg_buf[cnt[3:0] - 4'd15]) + msg_buf[cnt[3:0]];
    end

    assign in_ready  = (state == LOAD) && !rst;
    assign out_valid = (state == EMIT) && !rst;
    assign out_index = (state == EMIT) ? cnt : 6'd0;
    assign out_last  = out_valid && (cnt == 6'd63);
    assign out_data  = (cnt[5:4] == 2'b00) ? msg_buf[cnt[3:0]] : sched_dat;
    assign busy      = !rst && ((state == EMIT) || (cnt != 6'd0));
    assign in_acc    = in_valid && in_ready;
    assign out_acc   = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            LOAD: begin
                if (in_acc) begin
                    if (cnt == 6'd15) begin
                        state_nxt = EMIT;
                        cnt_nxt   = 6'd0;
                    end else begin
                        cnt_nxt = cnt + 6'd1;
                    end
                end
            end
            EMIT: begin
                if (out_acc) begin
                    if (cnt == 6'd63) begin
                        state_nxt = LOAD;
                        cnt_nxt   = 6'd0;
                    end else begin
                        cnt_nxt = cnt + 6'd1;
                    end
                end
            end
            default: begin
                state_nxt = LOAD;
                cnt_nxt   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            cnt   <= 6'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Buffer is not reset; W[t] overwrites W[t-16], which is no longer needed.
    always_ff @(posedge clk) begin
        if (in_acc) begin
            msg_buf[cnt[3:0]] <= in_data;
        end else if (out_acc && (cnt[5:4] != 2'b00)) begin
            msg_buf[cnt[3:0]] <= sched_dat;
        end
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched with a full 64-entry reference schedule model.
module tb_sha256_msg_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_index;
    logic        out_last;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] cur_blk [16];
    logic [31:0] exp_w   [64];
    logic [31:0] got_w   [64];
    logic [31:0] ref_w   [64];

    sha256_msg_sched dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic compute_model();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) exp_w[t] = cur_blk[t];
            else exp_w[t] = ssig1(exp_w[t-2]) + exp_w[t-7] + ssig0(exp_w[t-15]) + exp_w[t-16];
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) cur_blk[i] = 32'h0;
        cur_blk[0]  = 32'h61626380;
        cur_blk[15] = 32'h00000018;
    endtask

    task automatic set_fill(input logic [31:0] v);
        for (int i = 0; i < 16; i++) cur_blk[i] = v;
    endtask

    // Drives cur_blk into the DUT; returns before the posedge of the 16th accept.
    task automatic load_block(input bit rnd);
        int i = 0;
        int budget = 0;
        bit v;
        while (i < 16 && budget < 2000) begin
            @(negedge clk);
            budget++;
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL load_in_ready word=%0d got=%b want=1", i, in_ready);
            end
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL load_out_valid word=%0d got=%b want=0", i, out_valid);
            end
            total++;
            if (busy !== (i != 0)) begin
                bad++;
                $display("FAIL load_busy word=%0d got=%b want=%b", i, busy, (i != 0));
            end
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid = v;
            in_data  = v ? cur_blk[i] : (32'hBAD00000 ^ 32'(budget));
            if (v && in_ready) i++;
        end
        if (i < 16) begin
            bad++;
            $display("FAIL load_timeout accepted=%0d want=16", i);
        end
    endtask

    // Consumes words until t reaches stop_at (64 = whole block), checking each against exp_w.
    task automatic emit_block(input bit rnd, input int stop_at);
        int t = 0;
        int budget = 0;
        bit held = 1'b0;
        logic [31:0] held_dat = 32'h0;
        while (t < stop_at && budget < 2000) begin
            @(negedge clk);
            in_valid = 1'b0;
            budget++;
            total++;
            if (out_valid !== 1'b1) begin
                bad++;
                $display("FAIL emit_valid t=%0d got=%b want=1", t, out_valid);
                break;
            end
            total++;
            if (out_index !== 6'(t)) begin
                bad++;
                $display("FAIL emit_index got=%0d want=%0d", out_index, t);
            end
            total++;
            if (out_data !== exp_w[t]) begin
                bad++;
                $display("FAIL emit_data t=%0d got=%h want=%h", t, out_data, exp_w[t]);
            end
            total++;
            if (out_last !== (t == 63)) begin
                bad++;
                $display("FAIL emit_last t=%0d got=%b want=%b", t, out_last, (t == 63));
            end
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL emit_in_ready t=%0d got=%b want=0", t, in_ready);
            end
            if (held) begin
                total++;
                if (out_data !== held_dat) begin
                    bad++;
                    $display("FAIL stall_hold t=%0d got=%h want=%h", t, out_data, held_dat);
                end
            end
            got_w[t] = out_data;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            held      = !out_ready;
            held_dat  = out_data;
            if (out_ready) t++;
        end
        if (t < stop_at && budget >= 2000) begin
            bad++;
            $display("FAIL emit_timeout t=%0d want=%0d", t, stop_at);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({in_ready, out_valid, out_last, busy, out_index} !== 10'b0) begin
                bad++;
                $display("FAIL reset_outputs got rdy=%b vld=%b last=%b busy=%b idx=%0d want all 0",
                         in_ready, out_valid, out_last, busy, out_index);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got rdy=%b busy=%b vld=%b want 1/0/0", in_ready, busy, out_valid);
        end
    endtask

    task automatic test_basic();
        set_abc();
        compute_model();
        load_block(1'b0);
        emit_block(1'b0, 64);
        total++;
        if (got_w[16] !== 32'h61626380) begin
            bad++;
            $display("FAIL abc_w16 got=%h want=61626380", got_w[16]);
        end
        total++;
        if (got_w[17] !== 32'h000F0000) begin
            bad++;
            $display("FAIL abc_w17 got=%h want=000f0000", got_w[17]);
        end
        for (int t = 0; t < 64; t++) ref_w[t] = got_w[t];
    endtask

    task automatic test_sigma0();
        set_fill(32'h0);
        cur_blk[1] = 32'h00000080;
        compute_model();
        load_block(1'b0);
        emit_block(1'b0, 64);
        total++;
        if (got_w[16] !== 32'h00200011) begin
            bad++;
            $display("FAIL sigma0_w16 got=%h want=00200011", got_w[16]);
        end
    endtask

    task automatic test_backpressure();
        set_abc();
        compute_model();
        load_block(1'b1);
        emit_block(1'b1, 64);
        for (int t = 0; t < 64; t++) begin
            total++;
            if (got_w[t] !== ref_w[t]) begin
                bad++;
                $display("FAIL bp_vs_fullrate t=%0d got=%h want=%h", t, got_w[t], ref_w[t]);
            end
        end
    endtask

    task automatic test_back_to_back();
        set_fill(32'h13579BDF);
        compute_model();
        load_block(1'b0);
        emit_block(1'b0, 64);
        // load_block checks in_ready on the very next cycle after the W63 handshake
        set_fill(32'h0);
        cur_blk[1] = 32'h00000080;
        compute_model();
        load_block(1'b0);
        emit_block(1'b0, 64);
        total++;
        if (got_w[16] !== 32'h00200011) begin
            bad++;
            $display("FAIL b2b_w16 got=%h want=00200011", got_w[16]);
        end
    endtask

    task automatic test_carry_wrap();
        set_fill(32'hFFFFFFFF);
        compute_model();
        load_block(1'b0);
        emit_block(1'b0, 64);
    endtask

    task automatic test_reset_mid_emit();
        set_abc();
        compute_model();
        load_block(1'b0);
        emit_block(1'b0, 20);
        @(negedge clk);
        total++;
        if (out_index !== 6'd20 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_emit_pos got idx=%0d vld=%b want 20/1", out_index, out_valid);
        end
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_vld_immediate got=%b want=0", out_valid);
        end
        repeat (3) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL rst_hold got vld=%b rdy=%b want 0/0", out_valid, in_ready);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_index !== 6'd0) begin
            bad++;
            $display("FAIL rst_release got rdy=%b busy=%b vld=%b idx=%0d want 1/0/0/0",
                     in_ready, busy, out_valid, out_index);
        end
        // a fresh block must start from W0 with no leftover state
        set_fill(32'h0);
        cur_blk[1] = 32'h00000080;
        compute_model();
        load_block(1'b0);
        emit_block(1'b0, 64);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sigma0();
        test_backpressure();
        test_back_to_back();
        test_carry_wrap();
        test_reset_mid_emit();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
